fft_peak_analyzer: RTL and testbench



---
 rtl/fft_peak_analyzer.sv | 168 ++++++++++++++++
 tb/tb_fft_peak_analyzer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_analyzer.sv
// Peak-bin finder for one 16-bin complex FFT frame.
// Bins are squared and compared serially with a single squarer pair.
module fft_peak_analyzer #(
  parameter int NBINS   = 16,
  parameter int DW      = 16,
  parameter int SKIP_DC = 0,
  parameter int CNTW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fft_valid,
  input  logic [2*DW-1:0] fft_d0,
  input  logic [2*DW-1:0] fft_d1,
  input  logic [2*DW-1:0] fft_d2,
  input  logic [2*DW-1:0] fft_d3,
  input  logic [2*DW-1:0] fft_d4,
  input  logic [2*DW-1:0] fft_d5,
  input  logic [2*DW-1:0] fft_d6,
  input  logic [2*DW-1:0] fft_d7,
  input  logic [2*DW-1:0] fft_d8,
  input  logic [2*DW-1:0] fft_d9,
  input  logic [2*DW-1:0] fft_d10,
  input  logic [2*DW-1:0] fft_d11,
  input  logic [2*DW-1:0] fft_d12,
  input  logic [2*DW-1:0] fft_d13,
  input  logic [2*DW-1:0] fft_d14,
  input  logic [2*DW-1:0] fft_d15,
  output logic            ready,
  output logic            done,
  output logic [3:0]      freq,
  output logic [2*DW:0]   peak_mag,
  output logic [CNTW-1:0] frame_cnt,
  output logic            overrun
);

  localparam int MW = 2*DW+1;
  localparam logic [3:0] LAST = 4'(NBINS-1);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e          state_q, state_d;
  logic [2*DW-1:0] bank_q [NBINS];
  logic [2*DW-1:0] bank_d [NBINS];
  logic [2*DW-1:0] din    [NBINS];
  logic [3:0]      idx_q, idx_d;
  logic [3:0]      midx_q, midx_d;
  logic [MW-1:0]   max_q, max_d;
  logic            mvld_q, mvld_d;
  logic [3:0]      freq_q, freq_d;
  logic [MW-1:0]   peak_q, peak_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            ovr_q, ovr_d;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  logic [2*DW-1:0]        cur;
  logic signed [DW-1:0]   re, im;
  logic signed [2*DW-1:0] re_x, im_x;
  logic signed [2*DW-1:0] re2, im2;
  logic [MW-1:0]          mag;
  logic                   skip, upd;

  // Squares are non-negative and at most 2^30, so the MSB pad is exact.
  always_comb begin
    cur  = bank_q[idx_q];
    re   = cur[2*DW-1:DW];
    im   = cur[DW-1:0];
    re_x = {{DW{re[DW-1]}}, re};
    im_x = {{DW{im[DW-1]}}, im};
    re2  = re_x * re_x;
    im2  = im_x * im_x;
    mag  = {1'b0, re2} + {1'b0, im2};
    skip = (SKIP_DC != 0) && (idx_q == 4'd0);
    upd  = !skip && (!mvld_q || (mag > max_q));
  end

  always_comb begin
    state_d = state_q;
    bank_d  = bank_q;
    idx_d   = idx_q;
    midx_d  = midx_q;
    max_d   = max_q;
    mvld_d  = mvld_q;
    freq_d  = freq_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (fft_valid) begin
          bank_d  = din;
          idx_d   = 4'd0;
          midx_d  = 4'd0;
          max_d   = '0;
          mvld_d  = (SKIP_DC == 0);
          state_d = SCAN;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        if (fft_valid) ovr_d = 1'b1;
        if (upd) begin
          max_d  = mag;
          midx_d = idx_q;
          mvld_d = 1'b1;
        end
        idx_d = idx_q + 4'd1;
        if (idx_q == LAST) begin
          state_d = DONE;
          freq_d  = upd ? idx_q : midx_q;
          peak_d  = upd ? mag : max_q;
          cnt_d   = cnt_q + CNTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bank_q  <= '{default: '0};
      idx_q   <= '0;
      midx_q  <= '0;
      max_q   <= '0;
      mvld_q  <= 1'b0;
      freq_q  <= '0;
      peak_q  <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      midx_q  <= midx_d;
      max_q   <= max_d;
      mvld_q  <= mvld_d;
      freq_q  <= freq_d;
      peak_q  <= peak_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign ready     = (state_q == IDLE) || (state_q == DONE);
  assign done      = (state_q == DONE);
  assign freq      = freq_q;
  assign peak_mag  = peak_q;
  assign frame_cnt = cnt_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// Directed bench for fft_peak_analyzer: vector table plus
// back-to-back, overrun, mid-scan reset and counter wrap sequences.
module tb_fft_peak_analyzer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        fft_valid;
  logic [31:0] fr [16];

  logic        m_ready, m_done, m_ovr;
  logic [3:0]  m_freq;
  logic [32:0] m_peak;
  logic [7:0]  m_cnt;
  logic        s_ready, s_done, s_ovr;
  logic [3:0]  s_freq;
  logic [32:0] s_peak;
  logic [7:0]  s_cnt;

  fft_peak_analyzer #(.SKIP_DC(0)) dut (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fr[0]), .fft_d1(fr[1]), .fft_d2(fr[2]), .fft_d3(fr[3]),
    .fft_d4(fr[4]), .fft_d5(fr[5]), .fft_d6(fr[6]), .fft_d7(fr[7]),
    .fft_d8(fr[8]), .fft_d9(fr[9]), .fft_d10(fr[10]), .fft_d11(fr[11]),
    .fft_d12(fr[12]), .fft_d13(fr[13]), .fft_d14(fr[14]), .fft_d15(fr[15]),
    .ready(m_ready), .done(m_done), .freq(m_freq),
    .peak_mag(m_peak), .frame_cnt(m_cnt), .overrun(m_ovr)
  );

  fft_peak_analyzer #(.SKIP_DC(1)) dut_s (
    .clk(clk), .rst(rst), .fft_valid(fft_valid),
    .fft_d0(fr[0]), .fft_d1(fr[1]), .fft_d2(fr[2]), .fft_d3(fr[3]),
    .fft_d4(fr[4]), .fft_d5(fr[5]), .fft_d6(fr[6]), .fft_d7(fr[7]),
    .fft_d8(fr[8]), .fft_d9(fr[9]), .fft_d10(fr[10]), .fft_d11(fr[11]),
    .fft_d12(fr[12]), .fft_d13(fr[13]), .fft_d14(fr[14]), .fft_d15(fr[15]),
    .ready(s_ready), .done(s_done), .freq(s_freq),
    .peak_mag(s_peak), .frame_cnt(s_cnt), .overrun(s_ovr)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] fill;
    logic [3:0]  pa;
    logic [31:0] va;
    logic [3:0]  pb;
    logic [31:0] vb;
    logic [3:0]  efreq;
    logic [32:0] epeak;
    logic [3:0]  sfreq;
    logic [32:0] speak;
  } vec_t;

  vec_t tv [7];

  task automatic load(input vec_t v);
    for (int k = 0; k < 16; k++) fr[k] = v.fill;
    fr[v.pa] = v.va;
    fr[v.pb] = v.vb;
  endtask

  task automatic send_wait(output int lat);
    fft_valid = 1'b1;
    tick;
    fft_valid = 1'b0;
    lat = 1;
    while (!m_done && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  int lat;
  int nd;
  int cyc;

  initial begin
    tv[0] = '{32'h0010_0000, 4'd1, 32'h0400_0000, 4'd1, 32'h0400_0000,
              4'd1, 33'h10_0000, 4'd1, 33'h10_0000};
    tv[1] = '{32'h0, 4'd3, 32'h0300_FC00, 4'd15, 32'h0300_FC00,
              4'd3, 33'h19_0000, 4'd3, 33'h19_0000};
    tv[2] = '{32'h7FFF_0000, 4'd15, 32'h8000_8000, 4'd15, 32'h8000_8000,
              4'd15, 33'h8000_0000, 4'd15, 33'h8000_0000};
    tv[3] = '{32'h0, 4'd0, 32'h0, 4'd0, 32'h0,
              4'd0, 33'h0, 4'd1, 33'h0};
    tv[4] = '{32'h0, 4'd7, 32'hFF00_0000, 4'd9, 32'h0000_0200,
              4'd9, 33'h4_0000, 4'd9, 33'h4_0000};
    tv[5] = '{32'h0001_0001, 4'd0, 32'h0002_0000, 4'd0, 32'h0002_0000,
              4'd0, 33'h4, 4'd1, 33'h2};
    tv[6] = '{32'h0, 4'd0, 32'h7FFF_0000, 4'd2, 32'h0100_0000,
              4'd0, 33'h3FFF_0001, 4'd2, 33'h1_0000};

    rst = 1'b0;
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) fr[k] = '0;
    repeat (3) tick;
    chk("rst_done", m_done, 0);
    chk("rst_freq", m_freq, 0);
    chk("rst_peak", m_peak, 0);
    chk("rst_cnt", m_cnt, 0);
    chk("rst_ovr", m_ovr, 0);
    rst = 1'b1;
    tick;
    chk("rel_ready", m_ready, 1);

    for (int i = 0; i < 7; i++) begin
      load(tv[i]);
      send_wait(lat);
      chk($sformatf("v%0d_lat", i), 64'(lat), 17);
      chk($sformatf("v%0d_freq", i), m_freq, tv[i].efreq);
      chk($sformatf("v%0d_peak", i), m_peak, tv[i].epeak);
      chk($sformatf("v%0d_cnt", i), m_cnt, 64'(i + 1));
      chk($sformatf("v%0d_sdone", i), s_done, 1);
      chk($sformatf("v%0d_sfreq", i), s_freq, tv[i].sfreq);
      chk($sformatf("v%0d_speak", i), s_peak, tv[i].speak);
      tick;
      chk($sformatf("v%0d_pulse", i), m_done, 0);
      chk($sformatf("v%0d_hold", i), m_freq, tv[i].efreq);
    end
    chk("v_ovr", m_ovr, 0);

    // Frame X (peak bin 1), Y 17 cycles later (peak 15), Z dropped.
    for (int k = 0; k < 16; k++) fr[k] = '0;
    fr[1] = 32'h0200_0000;
    fft_valid = 1'b1;
    tick;
    fft_valid = 1'b0;
    repeat (16) tick;
    chk("bb_x_done", m_done, 1);
    chk("bb_x_freq", m_freq, 1);
    chk("bb_x_ready", m_ready, 1);
    for (int k = 0; k < 16; k++) fr[k] = '0;
    fr[15] = 32'h0100_0000;
    fft_valid = 1'b1;
    tick;
    fft_valid = 1'b0;
    chk("bb_y_busy", m_ready, 0);
    repeat (4) tick;
    for (int k = 0; k < 16; k++) fr[k] = '0;
    fr[2] = 32'h7FFF_0000;
    fft_valid = 1'b1;
    tick;
    fft_valid = 1'b0;
    chk("ovr_set", m_ovr, 1);
    repeat (11) tick;
    chk("bb_y_done", m_done, 1);
    chk("bb_y_freq", m_freq, 15);
    chk("bb_y_peak", m_peak, 33'h1_0000);
    nd = 0;
    repeat (25) begin
      tick;
      if (m_done) nd++;
    end
    chk("drop_nodone", 64'(nd), 0);
    chk("drop_freq", m_freq, 15);
    chk("ovr_sticky", m_ovr, 1);

    // Reset with scan index at 8.
    load(tv[0]);
    fft_valid = 1'b1;
    tick;
    fft_valid = 1'b0;
    repeat (8) tick;
    rst = 1'b0;
    tick;
    chk("mid_done", m_done, 0);
    chk("mid_freq", m_freq, 0);
    chk("mid_peak", m_peak, 0);
    chk("mid_cnt", m_cnt, 0);
    chk("mid_ovr", m_ovr, 0);
    rst = 1'b1;
    tick;
    chk("mid_ready", m_ready, 1);
    nd = 0;
    repeat (20) begin
      tick;
      if (m_done) nd++;
    end
    chk("mid_nodone", 64'(nd), 0);
    load(tv[1]);
    send_wait(lat);
    chk("post_lat", 64'(lat), 17);
    chk("post_freq", m_freq, 3);
    chk("post_cnt", m_cnt, 1);

    // Hold fft_valid: 255 more frames wrap the counter to 0.
    load(tv[0]);
    fft_valid = 1'b1;
    tick;
    nd = 0;
    cyc = 0;
    while (nd < 255 && cyc < 5000) begin
      tick;
      cyc++;
      if (m_done) nd++;
    end
    chk("wrap_frames", 64'(nd), 255);
    chk("wrap_cnt", m_cnt, 0);
    chk("wrap_freq", m_freq, 1);
    chk("wrap_ovr", m_ovr, 1);
    fft_valid = 1'b0;
    repeat (20) tick;
    chk("wrap_idle", m_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
